// File: rtl/gen_logic_pkg.sv
// Shared constants and helpers for the generate-selected bitwise operator FIFO.
package gen_logic_pkg;

  localparam int MODE_AND  = 0;
  localparam int MODE_OR   = 1;
  localparam int MODE_XOR  = 2;
  localparam int MODE_XNOR = 3;

  // Constant-foldable ceiling log2; evaluated at elaboration for widths.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/gen_logic_op.sv
// Single-lane bitwise operator, chosen at elaboration time; purely combinational.
module gen_logic_op
  import gen_logic_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MODE     = 0,
  parameter int INVERT_A = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] r
);

  logic [WIDTH-1:0] op_a;

  if (INVERT_A != 0) begin : g_inv
    assign op_a = ~a;
  end else begin : g_pass
    assign op_a = a;
  end

  // Unknown MODE values deliberately fall back to AND.
  case (MODE)
    MODE_OR:   begin : g_or   assign r = op_a | b;    end
    MODE_XOR:  begin : g_xor  assign r = op_a ^ b;    end
    MODE_XNOR: begin : g_xnor assign r = ~(op_a ^ b); end
    default:   begin : g_and  assign r = op_a & b;    end
  endcase

endmodule

// File: rtl/gen_logic_fifo.sv
// CHANNELS-lane bitwise operator whose results are queued in a DEPTH-entry FIFO.
module gen_logic_fifo
  import gen_logic_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2,
  parameter int MODE     = 0,
  parameter int INVERT_A = 0,
  parameter int DEPTH    = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_a,
  input  logic [CHANNELS*WIDTH-1:0] in_b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [clog2(DEPTH):0]     level,
  output logic [15:0]               xfer_count
);

  localparam int AW = clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = CHANNELS * WIDTH;

  logic [DW-1:0] result;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    gen_logic_op #(
      .WIDTH   (WIDTH),
      .MODE    (MODE),
      .INVERT_A(INVERT_A)
    ) u_op (
      .a(in_a[k*WIDTH +: WIDTH]),
      .b(in_b[k*WIDTH +: WIDTH]),
      .r(result[k*WIDTH +: WIDTH])
    );
  end

  // Handshake: a beat transfers on a side when valid and ready are both high at
  // the rising edge. in_ready ignores out_ready, so a full FIFO refuses input even
  // while it is being popped; out_valid never depends on in_valid (no bypass).
  assign in_ready  = (level != LW'(DEPTH));
  assign out_valid = (level != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  // Storage is not reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clock) begin
    if (push && !reset) mem[wr_ptr] <= result;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      xfer_count <= '0;
    end else begin
      if (push) begin
        wr_ptr     <= wr_ptr + AW'(1);
        xfer_count <= xfer_count + 16'd1;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_gen_logic_fifo.sv
// Bench for gen_logic_fifo: six instances (four modes, inverted-A OR, out-of-range mode)
// share one stimulus stream and are checked against a queue-based reference model.
module tb_gen_logic_fifo;

  localparam int NI = 6;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;

  logic        in_ready_w  [NI];
  logic        out_valid_w [NI];
  logic [15:0] out_data_w  [NI];
  logic [2:0]  level_w     [NI];
  logic [15:0] xfer_w      [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int GM = (g == 4) ? 1 : ((g == 5) ? 7 : g);
    localparam int GI = (g == 4) ? 1 : 0;
    gen_logic_fifo #(
      .WIDTH(8), .CHANNELS(2), .MODE(GM), .INVERT_A(GI), .DEPTH(4)
    ) u_dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready_w[g]),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid_w[g]),
      .out_ready (out_ready),
      .out_data  (out_data_w[g]),
      .level     (level_w[g]),
      .xfer_count(xfer_w[g])
    );
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: queue of accepted {a,b} operand pairs plus a transfer count.
  logic [31:0] exp_q[$];
  logic [15:0] m_xfer;
  int          n_checks;
  int          n_fail;

  // Instance 0:AND 1:OR 2:XOR 3:XNOR 4:OR with ~a 5:out-of-range mode -> AND.
  function automatic logic [15:0] f_ref(input int idx, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] aa;
    aa = (idx == 4) ? ~a : a;
    case (idx)
      1, 4:    return aa | b;
      2:       return aa ^ b;
      3:       return ~(aa ^ b);
      default: return aa & b;
    endcase
  endfunction

  function automatic logic [15:0] exp_head(input int idx);
    logic [31:0] h;
    if (exp_q.size() == 0) return 16'h0000;
    h = exp_q[0];
    return f_ref(idx, h[31:16], h[15:0]);
  endfunction

  // Advance one clock, updating the model from the inputs seen before the edge.
  task automatic tick();
    logic        do_push;
    logic        do_pop;
    logic [31:0] pair;
    do_push = !reset && in_valid && (exp_q.size() < 4);
    do_pop  = !reset && out_ready && (exp_q.size() > 0);
    pair    = {in_a, in_b};
    @(posedge clock);
    #1;
    if (reset) begin
      exp_q.delete();
      m_xfer = 16'h0000;
    end else begin
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) begin
        exp_q.push_back(pair);
        m_xfer = m_xfer + 16'd1;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks += 5;
    if (in_ready_w[2] !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready_w[2]); end
    if (out_valid_w[2] !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid_w[2]); end
    if (out_data_w[2] !== 16'h0000) begin n_fail++; $display("FAIL reset_out_data got=%h exp=0000", out_data_w[2]); end
    if (level_w[2] !== 3'd0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", level_w[2]); end
    if (xfer_w[2] !== 16'h0000) begin n_fail++; $display("FAIL reset_xfer got=%h exp=0000", xfer_w[2]); end
  endtask

  task automatic test_mode_sweep();
    logic [15:0] sweep_exp [NI];
    sweep_exp = '{16'hA088, 16'hFAEE, 16'h5A66, 16'hA599, 16'hAFBB, 16'hA088};
    do_reset();
    in_a = 16'hF0CC; in_b = 16'hAAAA; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < NI; i++) begin
      n_checks += 2;
      if (out_data_w[i] !== sweep_exp[i]) begin
        n_fail++; $display("FAIL mode_sweep_data inst=%0d got=%h exp=%h", i, out_data_w[i], sweep_exp[i]);
      end
      if (out_valid_w[i] !== 1'b1) begin
        n_fail++; $display("FAIL mode_sweep_valid inst=%0d got=%b exp=1", i, out_valid_w[i]);
      end
    end
    do_reset();
    in_a = 16'h00FF; in_b = 16'h0000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks += 2;
    if (out_data_w[4] !== 16'hFF00) begin n_fail++; $display("FAIL invert_a_on got=%h exp=FF00", out_data_w[4]); end
    if (out_data_w[1] !== 16'h00FF) begin n_fail++; $display("FAIL invert_a_off got=%h exp=00FF", out_data_w[1]); end
  endtask

  task automatic test_fill();
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin in_a = 16'($urandom); in_b = 16'($urandom); end
      tick();
      n_checks += 2;
      if (level_w[2] !== 3'(exp_q.size())) begin
        n_fail++; $display("FAIL fill_level step=%0d got=%0d exp=%0d", i, level_w[2], exp_q.size());
      end
      if (in_ready_w[2] !== (exp_q.size() != 4)) begin
        n_fail++; $display("FAIL fill_in_ready step=%0d got=%b exp=%b", i, in_ready_w[2], exp_q.size() != 4);
      end
    end
    n_checks += 3;
    if (level_w[2] !== 3'd4) begin n_fail++; $display("FAIL full_level got=%0d exp=4", level_w[2]); end
    if (xfer_w[2] !== 16'd4) begin n_fail++; $display("FAIL full_xfer got=%0d exp=4", xfer_w[2]); end
    if (in_ready_w[2] !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got=%b exp=0", in_ready_w[2]); end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_data_w[2] !== exp_head(2)) begin
        n_fail++; $display("FAIL drain_data step=%0d got=%h exp=%h", i, out_data_w[2], exp_head(2));
      end
      tick();
    end
    n_checks++;
    if (out_valid_w[2] !== 1'b0) begin n_fail++; $display("FAIL drain_empty got=%b exp=0", out_valid_w[2]); end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_a = 16'($urandom); in_b = 16'($urandom);
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_a = 16'($urandom); in_b = 16'($urandom);
      n_checks++;
      if (out_data_w[2] !== exp_head(2)) begin
        n_fail++; $display("FAIL b2b_data step=%0d got=%h exp=%h", i, out_data_w[2], exp_head(2));
      end
      tick();
      n_checks++;
      if (level_w[2] !== 3'd2) begin n_fail++; $display("FAIL b2b_level step=%0d got=%0d exp=2", i, level_w[2]); end
    end
    n_checks++;
    if (xfer_w[2] !== 16'd8) begin n_fail++; $display("FAIL b2b_xfer got=%0d exp=8", xfer_w[2]); end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    logic [15:0] wrap_exp [3];
    int          bad;
    wrap_exp = '{16'hFFFF, 16'h0000, 16'h0001};
    bad = 0;
    do_reset();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 65534; i++) begin
      in_a = 16'($urandom); in_b = 16'($urandom);
      tick();
      n_checks++;
      if (out_data_w[3] !== exp_head(3)) begin
        n_fail++;
        if (bad < 5) $display("FAIL wrap_data step=%0d got=%h exp=%h", i, out_data_w[3], exp_head(3));
        bad++;
      end
    end
    n_checks++;
    if (xfer_w[3] !== 16'hFFFE) begin n_fail++; $display("FAIL wrap_preload got=%h exp=FFFE", xfer_w[3]); end
    for (int i = 0; i < 3; i++) begin
      in_a = 16'($urandom); in_b = 16'($urandom);
      tick();
      n_checks += 2;
      if (xfer_w[3] !== wrap_exp[i]) begin
        n_fail++; $display("FAIL wrap_xfer step=%0d got=%h exp=%h", i, xfer_w[3], wrap_exp[i]);
      end
      if (out_data_w[3] !== exp_head(3)) begin
        n_fail++; $display("FAIL wrap_tail_data step=%0d got=%h exp=%h", i, out_data_w[3], exp_head(3));
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_a = 16'($urandom); in_b = 16'($urandom);
      tick();
    end
    n_checks++;
    if (level_w[2] !== 3'd3) begin n_fail++; $display("FAIL mid_pre_level got=%0d exp=3", level_w[2]); end
    reset = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    n_checks += 5;
    if (level_w[2] !== 3'd0) begin n_fail++; $display("FAIL mid_level got=%0d exp=0", level_w[2]); end
    if (out_valid_w[2] !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid got=%b exp=0", out_valid_w[2]); end
    if (out_data_w[2] !== 16'h0000) begin n_fail++; $display("FAIL mid_out_data got=%h exp=0000", out_data_w[2]); end
    if (xfer_w[2] !== 16'h0000) begin n_fail++; $display("FAIL mid_xfer got=%h exp=0000", xfer_w[2]); end
    if (in_ready_w[2] !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready got=%b exp=1", in_ready_w[2]); end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      // A stalled producer keeps its operands; otherwise draw fresh ones.
      if (!(in_valid && exp_q.size() == 4)) begin
        in_valid = 1'($urandom_range(0, 1));
        in_a = 16'($urandom); in_b = 16'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0) ? 1'b0 : 1'b1;
      if (c > 200) out_ready = 1'($urandom_range(0, 1));
      for (int i = 0; i < NI; i++) begin
        n_checks += 5;
        if (out_data_w[i] !== exp_head(i)) begin
          n_fail++; if (bad++ < 10) $display("FAIL rand_data cyc=%0d inst=%0d got=%h exp=%h", c, i, out_data_w[i], exp_head(i));
        end
        if (out_valid_w[i] !== (exp_q.size() != 0)) begin
          n_fail++; if (bad++ < 10) $display("FAIL rand_out_valid cyc=%0d inst=%0d got=%b", c, i, out_valid_w[i]);
        end
        if (in_ready_w[i] !== (exp_q.size() != 4)) begin
          n_fail++; if (bad++ < 10) $display("FAIL rand_in_ready cyc=%0d inst=%0d got=%b", c, i, in_ready_w[i]);
        end
        if (level_w[i] !== 3'(exp_q.size())) begin
          n_fail++; if (bad++ < 10) $display("FAIL rand_level cyc=%0d inst=%0d got=%0d exp=%0d", c, i, level_w[i], exp_q.size());
        end
        if (xfer_w[i] !== m_xfer) begin
          n_fail++; if (bad++ < 10) $display("FAIL rand_xfer cyc=%0d inst=%0d got=%0d exp=%0d", c, i, xfer_w[i], m_xfer);
        end
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; m_xfer = 16'h0000;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    test_reset();
    test_mode_sweep();
    test_fill();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
